// File: rtl/keyboard_pkg.sv
// Shared PS/2 set-2 constants and the scan-sequence FSM encoding used by the
// letter entry path.
package keyboard_pkg;

    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_EXT     = 2'd1,
        S_BRK     = 2'd2,
        S_EXT_BRK = 2'd3
    } kb_state_e;

endpackage

// File: rtl/letter_entry_ctrl_if.sv
// Scan-byte input and letter/counter output bundle between the keyboard
// receiver side and the level display side.
interface letter_entry_ctrl_if #(
    parameter int CNT_W = 8
);
    import keyboard_pkg::*;

    // scan_valid is a one-cycle strobe with no back-pressure: scan_code is
    // consumed on every cycle it is high; level_clear overrides it.
    logic [7:0]       scan_code;
    logic             scan_valid;
    logic             level_clear;
    logic [7:0]       letter;
    logic [CNT_W-1:0] counter;
    logic             key_strobe;
    logic             submitted;
    kb_state_e        dbg_state;

    modport master (
        output scan_code, scan_valid, level_clear,
        input  letter, counter, key_strobe, submitted, dbg_state
    );

    modport slave (
        input  scan_code, scan_valid, level_clear,
        output letter, counter, key_strobe, submitted, dbg_state
    );

endinterface

// File: rtl/scancode_to_ascii.sv
// Combinational PS/2 set-2 make code to uppercase ASCII map; non-letters
// report is_letter=0 and a space character.
module scancode_to_ascii
    import keyboard_pkg::*;
(
    input  logic [7:0] scan_code,
    output logic [7:0] ascii,
    output logic       is_letter
);

    always_comb begin
        ascii     = ASCII_SPACE;
        is_letter = 1'b1;
        case (scan_code)
            8'h1C: ascii = 8'h41;
            8'h32: ascii = 8'h42;
            8'h21: ascii = 8'h43;
            8'h23: ascii = 8'h44;
            8'h24: ascii = 8'h45;
            8'h2B: ascii = 8'h46;
            8'h34: ascii = 8'h47;
            8'h33: ascii = 8'h48;
            8'h43: ascii = 8'h49;
            8'h3B: ascii = 8'h4A;
            8'h42: ascii = 8'h4B;
            8'h4B: ascii = 8'h4C;
            8'h3A: ascii = 8'h4D;
            8'h31: ascii = 8'h4E;
            8'h44: ascii = 8'h4F;
            8'h4D: ascii = 8'h50;
            8'h15: ascii = 8'h51;
            8'h2D: ascii = 8'h52;
            8'h1B: ascii = 8'h53;
            8'h2C: ascii = 8'h54;
            8'h3C: ascii = 8'h55;
            8'h2A: ascii = 8'h56;
            8'h1D: ascii = 8'h57;
            8'h22: ascii = 8'h58;
            8'h35: ascii = 8'h59;
            8'h1A: ascii = 8'h5A;
            default: is_letter = 1'b0;
        endcase
    end

endmodule

// File: rtl/letter_entry_ctrl.sv
// Decodes PS/2 make/break/extended byte sequences into accepted letters and
// a guess position counter for the level display.
module letter_entry_ctrl
    import keyboard_pkg::*;
#(
    parameter int WORD_LEN = 5,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    letter_entry_ctrl_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WORD_LEN);
    localparam logic [CNT_W-1:0] CNT_SUB  = CNT_W'(WORD_LEN + 1);

    kb_state_e        state, state_nxt;
    logic [7:0]       held_code, held_code_nxt;
    logic             held_vld, held_vld_nxt;
    logic [7:0]       letter_q, letter_nxt;
    logic [CNT_W-1:0] counter_q, counter_nxt;
    logic             strobe_q, strobe_nxt;
    logic             submitted_q;
    logic [7:0]       map_ascii;
    logic             map_is_letter;

    scancode_to_ascii u_map (
        .scan_code (bus.scan_code),
        .ascii     (map_ascii),
        .is_letter (map_is_letter)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            held_code   <= 8'h00;
            held_vld    <= 1'b0;
            letter_q    <= 8'h00;
            counter_q   <= '0;
            strobe_q    <= 1'b0;
            submitted_q <= 1'b0;
        end else begin
            state       <= state_nxt;
            held_code   <= held_code_nxt;
            held_vld    <= held_vld_nxt;
            letter_q    <= letter_nxt;
            counter_q   <= counter_nxt;
            strobe_q    <= strobe_nxt;
            submitted_q <= (counter_nxt == CNT_SUB);
        end
    end

    always_comb begin
        state_nxt     = state;
        held_code_nxt = held_code;
        held_vld_nxt  = held_vld;
        letter_nxt    = letter_q;
        counter_nxt   = counter_q;
        strobe_nxt    = 1'b0;
        if (bus.level_clear) begin
            state_nxt    = S_IDLE;
            held_vld_nxt = 1'b0;
            letter_nxt   = 8'h00;
            counter_nxt  = '0;
        end else if (bus.scan_valid) begin
            case (state)
                S_IDLE: begin
                    if (bus.scan_code == SC_EXT) begin
                        state_nxt = S_EXT;
                    end else if (bus.scan_code == SC_BREAK) begin
                        state_nxt = S_BRK;
                    end else if (!(held_vld && bus.scan_code == held_code)) begin
                        // A fresh make; typematic repeats of the held key fall through.
                        held_code_nxt = bus.scan_code;
                        held_vld_nxt  = 1'b1;
                        if (map_is_letter && counter_q < CNT_FULL) begin
                            letter_nxt  = map_ascii;
                            counter_nxt = counter_q + 1'b1;
                            strobe_nxt  = 1'b1;
                        end else if (bus.scan_code == SC_ENTER && counter_q == CNT_FULL) begin
                            counter_nxt = CNT_SUB;
                            strobe_nxt  = 1'b1;
                        end
                    end
                end
                S_EXT: begin
                    state_nxt = (bus.scan_code == SC_BREAK) ? S_EXT_BRK : S_IDLE;
                end
                S_BRK: begin
                    if (held_vld && bus.scan_code == held_code) begin
                        held_vld_nxt = 1'b0;
                    end
                    state_nxt = S_IDLE;
                end
                default: begin
                    state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign bus.letter     = letter_q;
    assign bus.counter    = counter_q;
    assign bus.key_strobe = strobe_q;
    assign bus.submitted  = submitted_q;
    assign bus.dbg_state  = state;

endmodule

// File: tb/tb_letter_entry_ctrl.sv
// Bench for letter_entry_ctrl: directed scenarios with literal expectations
// plus randomized bytes checked every cycle against a behavioural model.
module tb_letter_entry_ctrl;

    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;
    logic check_en;

    letter_entry_ctrl_if #(.CNT_W(8)) bus ();

    letter_entry_ctrl #(.WORD_LEN(5), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- clock/reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [7:0] letter_codes [26];
    logic [7:0] m_letter;
    int         m_cnt;
    logic       m_strobe;
    logic       m_held;
    logic [7:0] m_held_code;
    logic       m_after_brk;
    logic       m_after_ext;
    logic [15:0] exp_q[$];

    initial begin
        letter_codes = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                         8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                         8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    end

    function automatic int letter_index(input logic [7:0] b);
        for (int i = 0; i < 26; i++) if (letter_codes[i] == b) return i;
        return -1;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        int idx;
        if (m_after_brk) begin
            // released key; only a plain (non-extended) release clears the hold
            if (!m_after_ext && m_held && b == m_held_code) m_held = 1'b0;
            m_after_brk = 1'b0;
            m_after_ext = 1'b0;
        end else if (b == 8'hF0) begin
            m_after_brk = 1'b1;
        end else if (m_after_ext) begin
            m_after_ext = 1'b0;
        end else if (b == 8'hE0) begin
            m_after_ext = 1'b1;
        end else if (!(m_held && b == m_held_code)) begin
            m_held      = 1'b1;
            m_held_code = b;
            idx = letter_index(b);
            if (idx >= 0 && m_cnt < 5) begin
                m_letter = 8'h41 + 8'(idx);
                m_cnt    = m_cnt + 1;
                m_strobe = 1'b1;
            end else if (b == 8'h5A && m_cnt == 5) begin
                m_cnt    = 6;
                m_strobe = 1'b1;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_letter = 8'h00; m_cnt = 0; m_strobe = 1'b0; m_held = 1'b0;
            m_held_code = 8'h00; m_after_brk = 1'b0; m_after_ext = 1'b0;
        end else begin
            m_strobe = 1'b0;
            if (bus.level_clear) begin
                m_letter = 8'h00; m_cnt = 0; m_held = 1'b0;
                m_after_brk = 1'b0; m_after_ext = 1'b0;
            end else if (bus.scan_valid) begin
                model_byte(bus.scan_code);
            end
            if (m_strobe) exp_q.push_back({8'(m_cnt), m_letter});
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (reset && check_en) begin
            check("letter",     32'(bus.letter),     32'(m_letter));
            check("counter",    32'(bus.counter),    32'(m_cnt));
            check("key_strobe", 32'(bus.key_strobe), 32'(m_strobe));
            check("submitted",  32'(bus.submitted),  32'(m_cnt == 6));
            if (bus.key_strobe) begin
                if (exp_q.size() == 0) check("strobe_queue_nonempty", 32'd0, 32'd1);
                else check("strobe_payload", {16'h0, bus.counter, bus.letter}, 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        bus.scan_code  = b;
        bus.scan_valid = 1'b1;
        @(posedge clk); #1;
        bus.scan_valid = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] seq[$]);
        foreach (seq[i]) send_byte(seq[i]);
    endtask

    task automatic pulse_clear();
        @(posedge clk); #1;
        bus.level_clear = 1'b1;
        @(posedge clk); #1;
        bus.level_clear = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        #12;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        pass_cnt = 0; total_cnt = 0; check_en = 1'b1;
        bus.scan_code = 8'h00; bus.scan_valid = 1'b0; bus.level_clear = 1'b0;
        reset = 1'b0;
        #23;
        check("reset_letter",    32'(bus.letter),     32'h00);
        check("reset_counter",   32'(bus.counter),    32'd0);
        check("reset_strobe",    32'(bus.key_strobe), 32'd0);
        check("reset_submitted", 32'(bus.submitted),  32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // 1: two letters with breaks
        send_byte(8'h4B);
        check("t1_letter_L",  32'(bus.letter), 32'h4C);
        check("t1_count1",    32'(bus.counter), 32'd1);
        check("t1_strobe1",   32'(bus.key_strobe), 32'd1);
        send_seq('{8'hF0, 8'h4B, 8'h44, 8'hF0, 8'h44});
        check("t1_letter_O",  32'(bus.letter), 32'h4F);
        check("t1_count2",    32'(bus.counter), 32'd2);

        // 2: typematic repeats suppressed until break
        pulse_clear();
        send_seq('{8'h4B, 8'h4B, 8'h4B, 8'hF0, 8'h4B, 8'h4B});
        check("t2_count",  32'(bus.counter), 32'd2);
        check("t2_letter", 32'(bus.letter), 32'h4C);

        // 3: full word, extra letter rejected, Enter submits
        pulse_clear();
        send_seq('{8'h4B, 8'hF0, 8'h4B, 8'h44, 8'hF0, 8'h44, 8'h34, 8'hF0, 8'h34,
                   8'h43, 8'hF0, 8'h43, 8'h21, 8'hF0, 8'h21, 8'h21, 8'hF0, 8'h21});
        check("t3_count_full", 32'(bus.counter), 32'd5);
        check("t3_letter_C",   32'(bus.letter), 32'h43);
        check("t3_not_sub",    32'(bus.submitted), 32'd0);
        send_byte(8'h5A);
        check("t3_count_sub",  32'(bus.counter), 32'd6);
        check("t3_submitted",  32'(bus.submitted), 32'd1);
        check("t3_letter_keep", 32'(bus.letter), 32'h43);
        send_seq('{8'hF0, 8'h5A, 8'h5A});
        check("t3_no_wrap",    32'(bus.counter), 32'd6);

        // 4: early Enter, extended and non-letter codes ignored
        pulse_clear();
        send_seq('{8'h1C, 8'hF0, 8'h1C, 8'h32, 8'hF0, 8'h32, 8'h5A, 8'hE0, 8'h4B, 8'h76});
        check("t4_count",  32'(bus.counter), 32'd2);
        check("t4_letter", 32'(bus.letter), 32'h42);

        // 5: level_clear wins over a same-cycle byte
        @(posedge clk); #1;
        bus.scan_code = 8'h1C; bus.scan_valid = 1'b1; bus.level_clear = 1'b1;
        @(posedge clk); #1;
        bus.scan_valid = 1'b0; bus.level_clear = 1'b0;
        check("t5_clr_count",  32'(bus.counter), 32'd0);
        check("t5_clr_letter", 32'(bus.letter), 32'h00);
        check("t5_clr_strobe", 32'(bus.key_strobe), 32'd0);
        send_byte(8'h1C);
        check("t5_count",  32'(bus.counter), 32'd1);
        check("t5_letter", 32'(bus.letter), 32'h41);

        // 6: reset in the middle of a break sequence
        send_byte(8'hF0);
        do_reset();
        send_byte(8'h34);
        check("t6_letter", 32'(bus.letter), 32'h47);
        check("t6_count",  32'(bus.counter), 32'd1);

        // randomized bytes, including back-to-back valids and rare clears
        for (int n = 0; n < 4000; n++) begin
            int sel;
            @(posedge clk); #1;
            sel = $urandom_range(0, 99);
            if (sel < 50)      bus.scan_code = letter_codes[$urandom_range(0, 25)];
            else if (sel < 72) bus.scan_code = 8'hF0;
            else if (sel < 82) bus.scan_code = 8'h5A;
            else if (sel < 88) bus.scan_code = 8'hE0;
            else               bus.scan_code = 8'($urandom_range(0, 255));
            bus.scan_valid  = ($urandom_range(0, 2) != 0);
            bus.level_clear = ($urandom_range(0, 79) == 0);
        end
        @(posedge clk); #1;
        bus.scan_valid = 1'b0; bus.level_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("strobe_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/letter_entry_ctrl.md
Name: letter_entry_ctrl

Overview:
Upstream stage of the level display. Consumes PS/2 set-2 scan-code bytes from the keyboard receiver and decodes make/break/extended sequences. Converts letter make codes to uppercase ASCII and tracks the guess position. Drives the `letter` and `counter` buses that the level display compares against the target word.

Parameters:
WORD_LEN, 5, number of letters per guess; Enter advances counter to WORD_LEN+1 (submit)
CNT_W, 8, width of counter output

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset; async assert, sync deassert handled upstream
scan_code  input  8  byte from the PS/2 receiver
scan_valid  input  1  one-cycle strobe; scan_code valid this cycle
level_clear  input  1  synchronous restart of entry for a new level/attempt
letter  output  8  ASCII of the last accepted letter (0x41–0x5A)
counter  output  CNT_W  number of accepted entries: 0..WORD_LEN+1
key_strobe  output  1  one-cycle pulse when letter/counter update
submitted  output  1  high while counter == WORD_LEN+1

Behaviour:
- Reset (reset==0, async): letter=8'h00, counter=0, key_strobe=0, submitted=0, FSM=S_IDLE, held_code=8'h00, held_vld=0.
- FSM advances only on cycles with scan_valid=1:
  - S_IDLE: 0xE0 -> S_EXT; 0xF0 -> S_BRK; any other byte is a make code (see accept rules).
  - S_EXT: 0xF0 -> S_EXT_BRK; any other byte is ignored (extended make) -> S_IDLE.
  - S_BRK: byte is the released code; if held_vld and byte==held_code, then held_vld<=0; -> S_IDLE.
  - S_EXT_BRK: byte ignored -> S_IDLE.
- Make code in S_IDLE:
  - Typematic repeat (held_vld && byte==held_code) is ignored.
  - Otherwise held_code<=byte and held_vld<=1, then:
    - Letter (A–Z map) and counter<WORD_LEN: letter<=ASCII, counter<=counter+1, key_strobe=1.
    - Enter (0x5A) and counter==WORD_LEN: counter<=WORD_LEN+1, letter unchanged, key_strobe=1.
    - All other codes, letters when counter>=WORD_LEN, and Enter when counter!=WORD_LEN: no output change, no strobe.
- Latency: the update is registered on the edge that samples scan_valid and is visible the following cycle. key_strobe is high for exactly that one cycle.
- counter never exceeds WORD_LEN+1; it does not wrap. No backspace: the display latches per-letter colours, so entries are final.
- submitted = (counter==WORD_LEN+1), registered together with counter.
- level_clear=1: counter=0, letter=8'h00, held_vld=0, FSM=S_IDLE, key_strobe=0.
  - Priority over scan_valid in the same cycle; that byte is dropped.
- Reset mid-sequence (e.g. after 0xF0): FSM returns to S_IDLE; the next byte is treated as a make code.
- scan_valid held high for multiple cycles is treated as multiple bytes; the upstream receiver guarantees a single-cycle pulse.

Decomposition:
- Shared package `keyboard_pkg`:
  - Constants SC_BREAK=8'hF0, SC_EXT=8'hE0, SC_ENTER=8'h5A.
  - FSM state enum (2-bit: S_IDLE, S_EXT, S_BRK, S_EXT_BRK).
  - ASCII_SPACE=8'h20.
- Sub-module `scancode_to_ascii`: combinational set-2 map.
  - Inputs: scan_code[7:0].
  - Outputs: ascii[7:0], is_letter.
  - Map: 1C=A 32=B 21=C 23=D 24=E 2B=F 34=G 33=H 43=I 3B=J 42=K 4B=L 3A=M 31=N 44=O 4D=P 15=Q 2D=R 1B=S 2C=T 3C=U 2A=V 1D=W 22=X 35=Y 1A=Z.

Test Plan:
1. Bytes 4B,F0,4B,44,F0,44 -> letter=0x4C then 0x4F; counter 1 then 2; two key_strobe pulses.
2. Bytes 4B,4B,4B,F0,4B,4B -> letter 0x4C accepted twice only (repeats suppressed until break); counter=2.
3. Type L,O,G,I,C with breaks, then 21,F0,21 (extra C) -> counter stays 5, letter=0x43; then 5A -> counter=6, submitted=1, letter=0x43.
4. Bytes 5A at counter=2 -> no change; E0,4B (extended) -> ignored, counter=2; 76 (Esc) -> ignored.
5. level_clear asserted in the same cycle as scan_valid with byte 1C -> counter=0, letter=0x00, no strobe; next byte 1C -> counter=1, letter=0x41.
6. Drive F0, then assert reset low mid-sequence, release; byte 34 -> accepted as make: letter=0x47, counter=1.
